// File: rtl/iob_eth_mdio_master_pkg.sv
`default_nettype none
// ============================================================================
// Module  : iob_eth_mdio_master_pkg
// Purpose : Shared frame constants, state encoding and header helper for the
//           clause-22 MDIO management master.
// Revision: 1.0 - initial release
// ============================================================================
package iob_eth_mdio_master_pkg;

  // Clause-22 frame codes
  localparam logic [1:0] c_st_code = 2'b01;
  localparam logic [1:0] c_op_rd   = 2'b10;
  localparam logic [1:0] c_op_wr   = 2'b01;

  // Field lengths in MDC periods
  localparam logic [5:0] c_pre_len  = 6'd32;
  localparam logic [5:0] c_hdr_len  = 6'd14;
  localparam logic [5:0] c_ta_len   = 6'd2;
  localparam logic [5:0] c_data_len = 6'd16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_HDR  = 3'd2,
    ST_TA   = 3'd3,
    ST_DATA = 3'd4
  } state_t;

  // ST, OP, PHYAD, REGAD packed MSB first, ready to be shifted out
  function automatic logic [13:0] hdr_word(input logic       rnw,
                                           input logic [4:0] phy_addr,
                                           input logic [4:0] reg_addr);
    return {c_st_code, (rnw ? c_op_rd : c_op_wr), phy_addr, reg_addr};
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_eth_mdio_master_if.sv
`default_nettype none
// ============================================================================
// Module  : iob_eth_mdio_master_if
// Purpose : Command/response bundle between CSR logic (master modport) and
//           the MDIO master (slave modport).
//   div_i, start_i, rnw_i, phy_addr_i, reg_addr_i, wdata_i : command
//   ready_o, done_o, rdata_o                               : response
//   pre_sup_i : only with IOB_ETH_MDIO_PREAMBLE_SUPPRESS_EN defined
// Revision: 1.0 - initial release
// ============================================================================
interface iob_eth_mdio_master_if #(
  parameter int DIV_W = 8
);
  logic [DIV_W-1:0] div_i;
  logic             start_i;
  logic             rnw_i;
  logic [4:0]       phy_addr_i;
  logic [4:0]       reg_addr_i;
  logic [15:0]      wdata_i;
`ifdef IOB_ETH_MDIO_PREAMBLE_SUPPRESS_EN
  logic             pre_sup_i;
`endif
  logic             ready_o;
  logic             done_o;
  logic [15:0]      rdata_o;

  modport master (
    output div_i, start_i, rnw_i, phy_addr_i, reg_addr_i, wdata_i,
`ifdef IOB_ETH_MDIO_PREAMBLE_SUPPRESS_EN
    output pre_sup_i,
`endif
    input  ready_o, done_o, rdata_o
  );

  modport slave (
    input  div_i, start_i, rnw_i, phy_addr_i, reg_addr_i, wdata_i,
`ifdef IOB_ETH_MDIO_PREAMBLE_SUPPRESS_EN
    input  pre_sup_i,
`endif
    output ready_o, done_o, rdata_o
  );
endinterface
`default_nettype wire

// File: rtl/iob_eth_mdio_master_shift.sv
`default_nettype none
// ============================================================================
// Module  : iob_eth_mdio_master_shift
// Purpose : 16-bit MSB-first shift register. Parallel load of write data,
//           serial out via q_o[15]/q_o[14], serial in of read data at LSB.
//   clk_i, arst_i, cke_i : clock, async reset, clock enable
//   load_i, load_data_i  : parallel load (has priority)
//   shift_i, ser_i       : shift left, new bit enters at bit 0
//   q_o                  : register contents
// Revision: 1.0 - initial release
// ============================================================================
module iob_eth_mdio_master_shift (
  input  wire logic        clk_i,
  input  wire logic        arst_i,
  input  wire logic        cke_i,
  input  wire logic        load_i,
  input  wire logic [15:0] load_data_i,
  input  wire logic        shift_i,
  input  wire logic        ser_i,
  output logic      [15:0] q_o
);
  logic [15:0] r_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_q <= 16'h0;
    end else if (cke_i) begin
      if (load_i) begin
        r_q <= load_data_i;
      end else if (shift_i) begin
        r_q <= {r_q[14:0], ser_i};
      end
    end
  end

  assign q_o = r_q;
endmodule
`default_nettype wire

// File: rtl/iob_eth_mdio_master.sv
`default_nettype none
// ============================================================================
// Module  : iob_eth_mdio_master
// Purpose : Clause-22 MDIO management master. Generates MDC from a modulo
//           divider, serialises one 64-bit (or 32-bit without preamble)
//           read/write frame per command and returns read data with a
//           one-cycle done strobe.
//   clk_i, cke_i, arst_i : clock, clock enable (low freezes), async reset
//   cmd                  : command/response interface (slave modport)
//   mdc_o                : management clock
//   mdio_o, mdio_oe_o    : MDIO pad output value and drive enable
//   mdio_i               : MDIO pad input
// Optional : IOB_ETH_MDIO_PREAMBLE_SUPPRESS_EN adds cmd.pre_sup_i, which
//            skips the 32-bit preamble for the accepted frame.
// Revision: 1.0 - initial release
// ============================================================================
module iob_eth_mdio_master
  import iob_eth_mdio_master_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  wire logic      clk_i,
  input  wire logic      cke_i,
  input  wire logic      arst_i,
  iob_eth_mdio_master_if.slave cmd,
  output logic           mdc_o,
  output logic           mdio_o,
  output logic           mdio_oe_o,
  input  wire logic      mdio_i
);
  state_t           r_state;
  logic [5:0]       r_bit_cnt;
  logic [DIV_W-1:0] r_div_cnt;
  logic [DIV_W-1:0] r_div;
  logic             r_mdc;
  logic             r_mdio;
  logic             r_oe;
  logic             r_ready;
  logic             r_done;
  logic [15:0]      r_rdata;
  logic             r_rnw;
  logic [13:0]      r_hdr;

  logic             w_accept;
  logic             w_tick;
  logic             w_fall;
  logic             w_rise;
  logic             w_shift;
  logic             w_skip_pre;
  logic [13:0]      w_hdr_in;
  logic [15:0]      w_sr_q;

`ifdef IOB_ETH_MDIO_PREAMBLE_SUPPRESS_EN
  assign w_skip_pre = cmd.pre_sup_i;
`else
  assign w_skip_pre = 1'b0;
`endif

  // ready_o is low in the done cycle, so a held start_i cannot re-trigger
  // until the cycle after completion.
  assign w_accept = (r_state == ST_IDLE) && r_ready && cmd.start_i;
  assign w_tick   = (r_div_cnt == r_div);
  assign w_fall   = (r_state != ST_IDLE) && w_tick && r_mdc;
  assign w_rise   = (r_state != ST_IDLE) && w_tick && !r_mdc;
  assign w_hdr_in = hdr_word(cmd.rnw_i, cmd.phy_addr_i, cmd.reg_addr_i);

  // Writes shift out on falling events (the last data bit needs no shift);
  // reads shift in on rising events.
  assign w_shift = (r_state == ST_DATA) &&
                   ((r_rnw && w_rise) ||
                    (!r_rnw && w_fall && (r_bit_cnt != c_data_len - 6'd1)));

  iob_eth_mdio_master_shift u_shift (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .cke_i       (cke_i),
    .load_i      (w_accept),
    .load_data_i (cmd.wdata_i),
    .shift_i     (w_shift),
    .ser_i       (mdio_i),
    .q_o         (w_sr_q)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 6'd0;
      r_div_cnt <= '0;
      r_div     <= '0;
      r_mdc     <= 1'b0;
      r_mdio    <= 1'b1;
      r_oe      <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_rdata   <= 16'h0;
      r_rnw     <= 1'b0;
      r_hdr     <= 14'h0;
    end else if (cke_i) begin
      r_done <= 1'b0;
      if (r_state == ST_IDLE) begin
        r_ready   <= 1'b1;
        r_div_cnt <= '0;
        r_mdc     <= 1'b0;
        if (w_accept) begin
          r_ready   <= 1'b0;
          r_rnw     <= cmd.rnw_i;
          r_hdr     <= w_hdr_in;
          r_div     <= cmd.div_i;
          r_bit_cnt <= 6'd0;
          r_oe      <= 1'b1;
          if (w_skip_pre) begin
            r_state <= ST_HDR;
            r_mdio  <= w_hdr_in[13];
          end else begin
            r_state <= ST_PRE;
            r_mdio  <= 1'b1;
          end
        end
      end else begin
        if (w_tick) begin
          r_div_cnt <= '0;
          r_mdc     <= ~r_mdc;
        end else begin
          r_div_cnt <= r_div_cnt + DIV_W'(1);
        end

        if (w_fall) begin
          r_bit_cnt <= r_bit_cnt + 6'd1;
          case (r_state)
            ST_PRE: begin
              if (r_bit_cnt == c_pre_len - 6'd1) begin
                r_state   <= ST_HDR;
                r_bit_cnt <= 6'd0;
                r_mdio    <= r_hdr[13];
              end else begin
                r_mdio <= 1'b1;
              end
            end
            ST_HDR: begin
              if (r_bit_cnt == c_hdr_len - 6'd1) begin
                r_state   <= ST_TA;
                r_bit_cnt <= 6'd0;
                r_mdio    <= 1'b1;
                r_oe      <= ~r_rnw;
              end else begin
                // header is consumed MSB first; bit 12 is the next one out
                r_hdr  <= {r_hdr[12:0], 1'b0};
                r_mdio <= r_hdr[12];
              end
            end
            ST_TA: begin
              if (r_bit_cnt == c_ta_len - 6'd1) begin
                r_state   <= ST_DATA;
                r_bit_cnt <= 6'd0;
                r_mdio    <= r_rnw ? 1'b1 : w_sr_q[15];
              end else begin
                // second TA bit: 0 for writes, released (idle high) for reads
                r_mdio <= r_rnw;
              end
            end
            ST_DATA: begin
              if (r_bit_cnt == c_data_len - 6'd1) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= 6'd0;
                r_mdio    <= 1'b1;
                r_oe      <= 1'b0;
                r_done    <= 1'b1;
                if (r_rnw) begin
                  r_rdata <= w_sr_q;
                end
              end else begin
                // the shift happening this edge moves bit 14 up to the MSB
                r_mdio <= r_rnw ? 1'b1 : w_sr_q[14];
              end
            end
            default: begin
              r_state <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign mdc_o       = r_mdc;
  assign mdio_o      = r_mdio;
  assign mdio_oe_o   = r_oe;
  assign cmd.ready_o = r_ready;
  // a strobe held over frozen cycles must not look like several pulses
  assign cmd.done_o  = r_done & cke_i;
  assign cmd.rdata_o = r_rdata;
endmodule
`default_nettype wire

// File: tb/tb_iob_eth_mdio_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_iob_eth_mdio_master
// Purpose : Self-checking bench for iob_eth_mdio_master. Stimulus pushes the
//           expected frame (bit image, drive mask, latency, read data) into a
//           scoreboard; a pin monitor captures MDIO at every MDC rise and
//           compares against the popped entry on each done strobe.
// Revision: 1.0 - initial release
// ============================================================================
module tb_iob_eth_mdio_master;

  logic clk     = 1'b0;
  logic cke     = 1'b1;
  logic arst    = 1'b1;
  logic mdio_in = 1'b1;
  logic mdc;
  logic mdio_out;
  logic mdio_oe;

  iob_eth_mdio_master_if #(.DIV_W(8)) cmd_if ();

  iob_eth_mdio_master #(.DIV_W(8)) dut (
    .clk_i     (clk),
    .cke_i     (cke),
    .arst_i    (arst),
    .cmd       (cmd_if),
    .mdc_o     (mdc),
    .mdio_o    (mdio_out),
    .mdio_oe_o (mdio_oe),
    .mdio_i    (mdio_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] bits;
    logic [63:0] oe;
    logic [15:0] rdata;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_vec    = 0;
  int          n_bad    = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  logic [15:0] last_rd  = 16'h0;
  logic [15:0] phy_rd   = 16'h0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- pin monitor + PHY responder ----------------
  logic        prev_ready = 1'b1;
  logic        prev_mdc   = 1'b0;
  int          acc_cyc    = 0;
  int          k          = 0;
  logic [63:0] cap_v      = '0;
  logic [63:0] cap_oe     = '0;

  always @(negedge clk) begin
    exp_t e;
    if (prev_ready && !cmd_if.ready_o) begin
      acc_cyc = cyc;
      k       = 0;
      cap_v   = '0;
      cap_oe  = '0;
    end
    if (!prev_mdc && mdc) begin
      if (k < 64) begin
        cap_v[63-k]  = mdio_out;
        cap_oe[63-k] = mdio_oe;
      end
      k++;
    end
    // PHY presents data bit for the next rising MDC edge (frame bits 48..63)
    if (k >= 48 && k < 64) mdio_in = phy_rd[15-(k-48)];
    else                   mdio_in = 1'b1;

    if (cmd_if.done_o) begin
      done_cnt++;
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done_o=1 required no done (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("latency", 64'(cyc - acc_cyc), 64'(e.lat));
        check("mdio_bits", cap_v & e.oe, e.bits & e.oe);
        check("mdio_oe", cap_oe, e.oe);
        check("mdc_rises", 64'(k), 64'd64);
        check("rdata", 64'(cmd_if.rdata_o), 64'(e.rdata));
      end
    end
    prev_ready = cmd_if.ready_o;
    prev_mdc   = mdc;
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int t = 0;
    while (cmd_if.ready_o !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_vec++;
      n_bad++;
      $display("FAIL ready_timeout: got ready_o=%b required 1", cmd_if.ready_o);
    end
  endtask

  task automatic wait_done(input int dc, input int bound);
    int t = 0;
    while (done_cnt == dc && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt == dc) begin
      n_vec++;
      n_bad++;
      $display("FAIL done_timeout: got no done_o within %0d cycles required one", bound);
    end
  endtask

  function automatic exp_t make_exp(input logic rnw, input logic [4:0] pa, input logic [4:0] ra,
                                    input logic [15:0] wd, input logic [15:0] rd, input int lat);
    exp_t e;
    e.bits  = {32'hFFFF_FFFF, 2'b01, (rnw ? 2'b10 : 2'b01), pa, ra, 2'b10, (rnw ? 16'h0 : wd)};
    e.oe    = rnw ? {{46{1'b1}}, 18'h0} : {64{1'b1}};
    e.rdata = rnw ? rd : last_rd;
    e.lat   = lat;
    return e;
  endfunction

  task automatic drive_cmd(input logic rnw, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input int d);
    cmd_if.rnw_i      = rnw;
    cmd_if.phy_addr_i = pa;
    cmd_if.reg_addr_i = ra;
    cmd_if.wdata_i    = wd;
    cmd_if.div_i      = 8'(d);
    cmd_if.start_i    = 1'b1;
  endtask

  // stall: cycles of cke=0 mid-frame; abort: pulse arst at bit 40 (no done)
  task automatic issue(input logic rnw, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, input logic [15:0] rd, input int d,
                       input int stall, input bit abort);
    int dc;
    wait_ready();
    if (!abort) begin
      sb.push_back(make_exp(rnw, pa, ra, wd, rd, 128 * (d + 1) + stall));
      if (rnw) last_rd = rd;
    end
    phy_rd = rd;
    dc     = done_cnt;
    drive_cmd(rnw, pa, ra, wd, d);
    @(negedge clk);
    cmd_if.start_i = 1'b0;
    cmd_if.div_i   = 8'($urandom);
    check("ready_drop", 64'(cmd_if.ready_o), 64'd0);
    if (abort) begin
      repeat (80) @(negedge clk);
      arst = 1'b1;
      #1;
      check("rst_mdc", 64'(mdc), 64'd0);
      check("rst_oe", 64'(mdio_oe), 64'd0);
      check("rst_mdio", 64'(mdio_out), 64'd1);
      check("rst_ready", 64'(cmd_if.ready_o), 64'd1);
      check("rst_rdata", 64'(cmd_if.rdata_o), 64'd0);
      check("rst_done", 64'(cmd_if.done_o), 64'd0);
      last_rd = 16'h0;
      @(negedge clk);
      arst = 1'b0;
      return;
    end
    if (stall > 0) begin
      repeat (30) @(negedge clk);
      cke = 1'b0;
      repeat (stall) @(negedge clk);
      cke = 1'b1;
    end
    wait_done(dc, 128 * (d + 1) + stall + 100);
  endtask

  initial begin
    int dc;
    cmd_if.div_i      = 8'd0;
    cmd_if.start_i    = 1'b0;
    cmd_if.rnw_i      = 1'b0;
    cmd_if.phy_addr_i = 5'd0;
    cmd_if.reg_addr_i = 5'd0;
    cmd_if.wdata_i    = 16'h0;
`ifdef IOB_ETH_MDIO_PREAMBLE_SUPPRESS_EN
    cmd_if.pre_sup_i  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    check("reset_mdc", 64'(mdc), 64'd0);
    check("reset_mdio", 64'(mdio_out), 64'd1);
    check("reset_oe", 64'(mdio_oe), 64'd0);
    check("reset_ready", 64'(cmd_if.ready_o), 64'd1);
    check("reset_done", 64'(cmd_if.done_o), 64'd0);
    check("reset_rdata", 64'(cmd_if.rdata_o), 64'd0);

    // directed frames from the plan
    issue(1'b0, 5'h01, 5'h00, 16'h1140, 16'h0000, 0, 0, 1'b0);
    issue(1'b1, 5'h03, 5'h02, 16'h0000, 16'h0141, 1, 0, 1'b0);

    // start held through a frame, div_i changed mid-frame
    wait_ready();
    sb.push_back(make_exp(1'b0, 5'h0A, 5'h11, 16'hBEEF, 16'h0, 128));
    dc = done_cnt;
    drive_cmd(1'b0, 5'h0A, 5'h11, 16'hBEEF, 0);
    repeat (20) @(negedge clk);
    cmd_if.div_i = 8'd5;
    wait_done(dc, 300);
    cmd_if.start_i = 1'b0;
    repeat (4) @(negedge clk);
    check("no_requeue_ready", 64'(cmd_if.ready_o), 64'd1);

    // cke freeze for 10 cycles mid-frame
    issue(1'b0, 5'h07, 5'h1F, 16'hA5C3, 16'h0, 0, 10, 1'b0);
    // reset during bit 40, then a normal frame
    issue(1'b0, 5'h02, 5'h04, 16'h1234, 16'h0, 0, 0, 1'b1);
    issue(1'b0, 5'h02, 5'h04, 16'h5678, 16'h0, 0, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      issue(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 16'($urandom),
            16'($urandom), int'($urandom_range(0, 3)), 0, 1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/iob_eth_mdio_master.md
Name: iob_eth_mdio_master

Overview:
- MDIO (IEEE 802.3 clause 22) management master for the Ethernet PHY.
- MDC is generated by an internal modulo divider. The block serialises one read or write frame per command, samples read data, and returns it on a single-cycle completion strobe.
- Sits between the core's CSR/control logic, which issues commands, and the PHY pins (MDC, bidirectional MDIO via tri-state enable).

Parameters:
- DIV_W, 8, width of the MDC half-period divider value.

Ports:
- clk_i  input  1  system clock.
- cke_i  input  1  clock enable; low freezes all state.
- arst_i  input  1  asynchronous reset, active-high.
- div_i  input  DIV_W  MDC half-period minus 1, in clk cycles.
- start_i  input  1  command request; accepted only when ready_o=1.
- rnw_i  input  1  1=read, 0=write.
- phy_addr_i  input  5  PHY address.
- reg_addr_i  input  5  register address.
- wdata_i  input  16  write data.
- ready_o  output  1  idle, able to accept start_i.
- done_o  output  1  one-cycle pulse at frame end (read and write).
- rdata_o  output  16  last read data; held until the next read completes.
- mdc_o  output  1  management clock.
- mdio_o  output  1  MDIO output value.
- mdio_oe_o  output  1  MDIO output enable (1=drive).
- mdio_i  input  1  MDIO input from pad.

Behaviour:
- Reset (arst_i=1, asynchronous, any time including mid-frame):
  - state IDLE; divider=0.
  - mdc_o=0, mdio_o=1, mdio_oe_o=0, ready_o=1, done_o=0, rdata_o=0.
- Accept:
  - In IDLE with start_i=1 (and cke_i=1), latch rnw, phy_addr, reg_addr, wdata and div_i.
  - div_i changes mid-frame are ignored.
  - ready_o drops the next cycle.
  - start_i while busy is ignored; no queueing.
- Divider:
  - Counts 0..D, where D is the latched div_i.
  - On reaching D it wraps to 0 and toggles mdc_o.
  - Half-period = D+1 cycles; D=0 gives a 2-cycle MDC.
- Edge events:
  - Falling event (mdc 1->0): advance to the next bit and drive it.
  - Rising event (mdc 0->1): sample mdio_i.
  - Bit 0 is driven in the cycle after acceptance, with mdc_o=0.
- Frame bits, MSB first:
  - PRE: 32 ones.
  - ST: 01.
  - OP: 10 for read, 01 for write.
  - PHYAD: 5 bits. REGAD: 5 bits.
  - TA: write drives 1,0; read releases MDIO (oe=0).
  - DATA: 16 bits. Write drives wdata; read keeps oe=0 and shifts in mdio_i on each rising event.
- States and transitions:
  - IDLE -> PRE -> HDR (14 bits) -> TA (2 bits) -> DATA (16 bits) -> IDLE.
  - A 6-bit bit counter runs inside each state.
- mdio_oe_o:
  - 1 from bit 0 through bit 45 for reads; through bit 63 for writes.
  - 0 in IDLE.
- End of frame:
  - At the falling event following bit 63's rising event: state becomes IDLE, mdc_o=0, oe=0, mdio_o=1.
  - done_o=1 for exactly one cycle. For reads, rdata_o is updated in that same cycle.
  - ready_o=1 in the following cycle.
- Latency: acceptance-to-done_o = 64*2*(D+1) cycles when cke_i stays high.
- cke_i=0: all registers hold; done_o is not emitted while frozen.

Optional Feature:
- Macro IOB_ETH_MDIO_PREAMBLE_SUPPRESS_EN.
- When defined:
  - Adds input port pre_sup_i (1 bit), latched at accept.
  - If set, PRE is skipped: 32-bit frame, latency 32*2*(D+1) cycles.
- When undefined: the port is absent and the preamble is always sent.

Decomposition:
- Shared header iob_eth_mdio_conf.vh holds:
  - ST_CODE=2'b01, OP_RD=2'b10, OP_WR=2'b01.
  - PRE_LEN=32, HDR_LEN=14, TA_LEN=2, DATA_LEN=16.
  - State encodings IDLE/PRE/HDR/TA/DATA.
- One sub-module, iob_eth_mdio_shift:
  - 16-bit shift register with parallel load, serial out (write) and serial in (read).
  - Enable driven by the falling/rising edge events.

Test Plan:
- Write, D=0, phy 5'h01, reg 5'h00, wdata 16'h1140 -> MDIO sequence: 32 ones, then 01 01 00001 00000 10 0001000101000000. oe=1 for all 64 bits. done_o at cycle 128. mdc period 2.
- Read, D=1, phy 5'h03, reg 5'h02, PHY model drives 16'h0141 on falling edges -> oe=0 for bits 46..63. rdata_o=16'h0141 with done_o at cycle 256. Write fields/TA not driven.
- start_i held high through a frame, and div_i changed 0->5 at cycle 20 -> exactly one frame; latency stays 128 (D=0). Second start is accepted only after ready_o=1.
- arst_i pulsed during bit 40 -> same cycle: mdc_o=0, oe=0, mdio_o=1, ready_o=1, rdata_o=0, no done_o. Next write completes normally.
- cke_i low for 10 cycles mid-frame -> outputs frozen; done_o at cycle 138 (D=0).
- With IOB_ETH_MDIO_PREAMBLE_SUPPRESS_EN and pre_sup_i=1, D=0 write -> first driven bits 01; done_o at cycle 64. With pre_sup_i=0 -> 128.
